// File: rtl/tl_beat_queue.sv
// rtl/tl_beat_queue.sv - valid/ready queue for one packed TileLink channel beat
//
// Purpose:
//   Sits between the packed tile wrapper and the interconnect on one channel
//   (A..E) or on the broadcast trace port. Stores up to DEPTH beats in a
//   circular buffer. Optional pipe mode lets a full queue accept a beat in
//   the same cycle it dequeues. Optional flow mode lets an empty queue forward
//   a beat combinationally. Optional drop-when-full mode lets a producer that
//   has no ready input keep streaming: beats with no space are discarded and
//   counted.
//
// Ports:
//   clock_i      rising-edge clock for all state
//   reset_i      synchronous reset, active-high
//   flush_i      synchronous discard of all stored entries
//   enq_valid_i  producer beat valid
//   enq_ready_o  queue can accept (constant 1 in drop-when-full mode
//                outside reset and flush)
//   enq_beat_i   packed beat from the producer
//   deq_valid_o  beat available at the head
//   deq_ready_i  consumer accepts the head beat
//   deq_beat_o   packed beat at the head (or the bypassed beat)
//   count_o      number of stored entries; bypassed beats are not counted
//   drops_o      saturating count of discarded beats; cleared only by reset

module tl_beat_queue #(
    parameter int WIDTH          = 620,
    parameter int DEPTH          = 2,
    parameter int PIPE           = 0,
    parameter int FLOW           = 0,
    parameter int DROP_WHEN_FULL = 0
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic                         flush_i,
    input  logic                         enq_valid_i,
    output logic                         enq_ready_o,
    input  logic [WIDTH-1:0]             enq_beat_i,
    output logic                         deq_valid_o,
    input  logic                         deq_ready_i,
    output logic [WIDTH-1:0]             deq_beat_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic [15:0]                  drops_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // The storage array is rounded up to a power of two so any pointer value
    // indexes a real slot; the pointers themselves wrap at DEPTH-1, so the
    // slots above DEPTH-1 are never written or read.
    localparam int SLOTS = 1 << PW;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    localparam logic PIPE_EN = (PIPE != 0);
    localparam logic FLOW_EN = (FLOW != 0);
    localparam logic DROP_EN = (DROP_WHEN_FULL != 0);

    logic [WIDTH-1:0] mem [SLOTS];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic [15:0]      drops;

    logic active;
    logic empty;
    logic full;
    logic can_accept;
    logic enq_fire;
    logic drop;
    logic bypass;
    logic deq_fire;
    logic bypass_fire;
    logic do_enq;
    logic do_deq;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Reset and flush both freeze the handshake for the cycle: nothing is
    // accepted, nothing is offered, nothing is counted as dropped.
    assign active = !reset_i && !flush_i;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    // Pipe mode: a full queue may take a beat when the head leaves this
    // cycle. deq_ready_i only reaches enq_ready_o through this term.
    assign can_accept = (count < FULL_CNT) || (PIPE_EN && deq_ready_i && full);

    assign enq_fire = active && enq_valid_i && can_accept;
    assign drop     = active && DROP_EN && enq_valid_i && !can_accept;

    // Flow mode: an empty queue offers the incoming beat directly.
    // enq_valid_i only reaches deq_valid_o through this term.
    assign bypass = FLOW_EN && empty && enq_valid_i;

    always_comb begin
        enq_ready_o = 1'b0;
        deq_valid_o = 1'b0;
        if (active) begin
            enq_ready_o = DROP_EN ? 1'b1 : can_accept;
            deq_valid_o = !empty || bypass;
        end
    end

    assign deq_beat_o = empty ? enq_beat_i : mem[rd_ptr];

    assign deq_fire = deq_valid_o && deq_ready_i;

    // A beat that is both enqueued and dequeued while the queue is empty can
    // only have come through the bypass path: it never touches storage.
    assign bypass_fire = empty && enq_fire && deq_fire;
    assign do_enq      = enq_fire && !bypass_fire;
    assign do_deq      = deq_fire && !empty;

    assign count_o = count;
    assign drops_o = drops;

    // Storage is not reset; stale contents are unreachable once count is 0.
    always_ff @(posedge clock_i) begin
        if (do_enq) begin
            mem[wr_ptr] <= enq_beat_i;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_enq) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_deq) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_enq, do_deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // The drop counter survives flush so a trace consumer can still see how
    // many beats were lost before it cleared the queue.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            drops <= '0;
        end else if (drop && (drops != 16'hFFFF)) begin
            drops <= drops + 16'd1;
        end
    end

endmodule

// File: tb/tb_tl_beat_queue.sv
// tb/tb_tl_beat_queue.sv - self-checking bench for tl_beat_queue
module tb_tl_beat_queue;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // a: DEPTH=2 default, w: DEPTH=3, p: PIPE DEPTH=1, f: FLOW DEPTH=2, d: DROP DEPTH=2
    logic a_fl, a_ev, a_dr, a_er, a_dv;  logic [15:0] a_eb, a_db, a_drops; logic [1:0] a_cnt;
    logic w_fl, w_ev, w_dr, w_er, w_dv;  logic [15:0] w_eb, w_db, w_drops; logic [1:0] w_cnt;
    logic p_fl, p_ev, p_dr, p_er, p_dv;  logic [15:0] p_eb, p_db, p_drops; logic [0:0] p_cnt;
    logic f_fl, f_ev, f_dr, f_er, f_dv;  logic [15:0] f_eb, f_db, f_drops; logic [1:0] f_cnt;
    logic d_fl, d_ev, d_dr, d_er, d_dv;  logic [15:0] d_eb, d_db, d_drops; logic [1:0] d_cnt;

    tl_beat_queue #(.WIDTH(16), .DEPTH(2)) dut_a (
        .clock_i(clk), .reset_i(rst), .flush_i(a_fl), .enq_valid_i(a_ev), .enq_ready_o(a_er),
        .enq_beat_i(a_eb), .deq_valid_o(a_dv), .deq_ready_i(a_dr), .deq_beat_o(a_db),
        .count_o(a_cnt), .drops_o(a_drops));
    tl_beat_queue #(.WIDTH(16), .DEPTH(3)) dut_w (
        .clock_i(clk), .reset_i(rst), .flush_i(w_fl), .enq_valid_i(w_ev), .enq_ready_o(w_er),
        .enq_beat_i(w_eb), .deq_valid_o(w_dv), .deq_ready_i(w_dr), .deq_beat_o(w_db),
        .count_o(w_cnt), .drops_o(w_drops));
    tl_beat_queue #(.WIDTH(16), .DEPTH(1), .PIPE(1)) dut_p (
        .clock_i(clk), .reset_i(rst), .flush_i(p_fl), .enq_valid_i(p_ev), .enq_ready_o(p_er),
        .enq_beat_i(p_eb), .deq_valid_o(p_dv), .deq_ready_i(p_dr), .deq_beat_o(p_db),
        .count_o(p_cnt), .drops_o(p_drops));
    tl_beat_queue #(.WIDTH(16), .DEPTH(2), .FLOW(1)) dut_f (
        .clock_i(clk), .reset_i(rst), .flush_i(f_fl), .enq_valid_i(f_ev), .enq_ready_o(f_er),
        .enq_beat_i(f_eb), .deq_valid_o(f_dv), .deq_ready_i(f_dr), .deq_beat_o(f_db),
        .count_o(f_cnt), .drops_o(f_drops));
    tl_beat_queue #(.WIDTH(16), .DEPTH(2), .DROP_WHEN_FULL(1)) dut_d (
        .clock_i(clk), .reset_i(rst), .flush_i(d_fl), .enq_valid_i(d_ev), .enq_ready_o(d_er),
        .enq_beat_i(d_eb), .deq_valid_o(d_dv), .deq_ready_i(d_dr), .deq_beat_o(d_db),
        .count_o(d_cnt), .drops_o(d_drops));

    typedef struct {
        logic        ev;
        logic [15:0] eb;
        logic        dr;
        logic        fl;
        logic        er;
        logic        dv;
        logic        chk_db;
        logic [15:0] db;
        logic [1:0]  cnt;
    } vec_t;

    function automatic vec_t mk(input logic ev, input logic [15:0] eb, input logic dr,
                                input logic fl, input logic er, input logic dv,
                                input logic chk_db, input logic [15:0] db, input logic [1:0] cnt);
        vec_t v;
        v.ev = ev; v.eb = eb; v.dr = dr; v.fl = fl; v.er = er; v.dv = dv;
        v.chk_db = chk_db; v.db = db; v.cnt = cnt;
        return v;
    endfunction

    vec_t vt [15];

    initial begin
        int sent;
        int got;
        int qsz;
        int notrdy;

        // Expected outputs observed before the edge that applies each vector.
        vt[0]  = mk(1, 16'h1, 0, 0,  1, 0, 0, 16'h0, 2'd0);
        vt[1]  = mk(1, 16'h2, 0, 0,  1, 1, 1, 16'h1, 2'd1);
        vt[2]  = mk(1, 16'h3, 0, 0,  0, 1, 1, 16'h1, 2'd2);
        vt[3]  = mk(1, 16'h3, 1, 0,  0, 1, 1, 16'h1, 2'd2);
        vt[4]  = mk(1, 16'h3, 1, 0,  1, 1, 1, 16'h2, 2'd1);
        vt[5]  = mk(0, 16'h0, 1, 0,  1, 1, 1, 16'h3, 2'd1);
        vt[6]  = mk(0, 16'h0, 1, 0,  1, 0, 0, 16'h0, 2'd0);
        vt[7]  = mk(1, 16'h4, 0, 0,  1, 0, 0, 16'h0, 2'd0);
        vt[8]  = mk(1, 16'h5, 0, 0,  1, 1, 1, 16'h4, 2'd1);
        vt[9]  = mk(1, 16'h6, 1, 1,  0, 0, 0, 16'h0, 2'd2);
        vt[10] = mk(0, 16'h0, 1, 0,  1, 0, 0, 16'h0, 2'd0);
        vt[11] = mk(1, 16'h7, 0, 0,  1, 0, 0, 16'h0, 2'd0);
        vt[12] = mk(0, 16'h0, 0, 0,  1, 1, 1, 16'h7, 2'd1);
        vt[13] = mk(0, 16'h0, 1, 0,  1, 1, 1, 16'h7, 2'd1);
        vt[14] = mk(0, 16'h0, 0, 0,  1, 0, 0, 16'h0, 2'd0);

        rst = 1'b1;
        {a_fl, a_ev, a_dr, a_eb} = '0;
        {w_fl, w_ev, w_dr, w_eb} = '0;
        {p_fl, p_ev, p_dr, p_eb} = '0;
        {f_fl, f_ev, f_dr, f_eb} = '0;
        {d_fl, d_ev, d_dr, d_eb} = '0;
        d_ev = 1'b1;
        tick();
        tick();
        #1;
        chk("rst_a_er", 32'(a_er), 0);
        chk("rst_d_er", 32'(d_er), 0);
        chk("rst_a_dv", 32'(a_dv), 0);
        d_ev = 1'b0;
        rst  = 1'b0;
        #1;
        chk("post_rst_a_er", 32'(a_er), 1);
        chk("post_rst_a_dv", 32'(a_dv), 0);
        chk("post_rst_a_cnt", 32'(a_cnt), 0);
        chk("post_rst_d_drops", 32'(d_drops), 0);
        tick();

        // Table: DEPTH=2 fill/stall/drain, then flush with two entries.
        for (int i = 0; i < 15; i++) begin
            a_ev = vt[i].ev; a_eb = vt[i].eb; a_dr = vt[i].dr; a_fl = vt[i].fl;
            #1;
            chk($sformatf("vec%0d_er", i), 32'(a_er), 32'(vt[i].er));
            chk($sformatf("vec%0d_dv", i), 32'(a_dv), 32'(vt[i].dv));
            chk($sformatf("vec%0d_cnt", i), 32'(a_cnt), 32'(vt[i].cnt));
            if (vt[i].chk_db) chk($sformatf("vec%0d_db", i), 32'(a_db), 32'(vt[i].db));
            chk($sformatf("vec%0d_drops", i), 32'(a_drops), 0);
            tick();
        end
        {a_fl, a_ev, a_dr} = '0;

        // DEPTH=3 wrap with random consumer stalls.
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 300 && got < 10; cyc++) begin
            qsz  = sent - got;
            w_ev = (sent < 10);
            w_eb = 16'(sent);
            w_dr = 1'($urandom_range(0, 1));
            #1;
            chk("wrap_cnt", 32'(w_cnt), 32'(qsz));
            chk("wrap_dv", 32'(w_dv), 32'(qsz > 0));
            chk("wrap_er", 32'(w_er), 32'(qsz < 3));
            if (w_dv && w_dr) begin
                chk("wrap_db", 32'(w_db), 32'(got));
                got++;
            end
            if (w_ev && w_er) sent++;
            tick();
        end
        chk("wrap_got", 32'(got), 10);
        {w_ev, w_dr} = '0;

        // PIPE=1, DEPTH=1.
        p_ev = 1'b1; p_eb = 16'h11; p_dr = 1'b0;
        #1;
        chk("pipe_er_empty", 32'(p_er), 1);
        tick();
        p_eb = 16'h22;
        #1;
        chk("pipe_er_full_noready", 32'(p_er), 0);
        chk("pipe_db_old", 32'(p_db), 16'h11);
        p_dr = 1'b1;
        #1;
        chk("pipe_er_full_ready", 32'(p_er), 1);
        tick();
        p_ev = 1'b0; p_dr = 1'b0;
        #1;
        chk("pipe_cnt", 32'(p_cnt), 1);
        chk("pipe_db_new", 32'(p_db), 16'h22);
        p_dr = 1'b1;
        tick();
        p_dr = 1'b0;
        #1;
        chk("pipe_cnt_drained", 32'(p_cnt), 0);

        // FLOW=1 bypass and bypass-with-stall.
        f_ev = 1'b1; f_eb = 16'hAB; f_dr = 1'b1;
        #1;
        chk("flow_dv", 32'(f_dv), 1);
        chk("flow_db", 32'(f_db), 16'hAB);
        chk("flow_cnt", 32'(f_cnt), 0);
        tick();
        f_ev = 1'b0; f_dr = 1'b0;
        #1;
        chk("flow_cnt_after", 32'(f_cnt), 0);
        chk("flow_dv_after", 32'(f_dv), 0);
        f_ev = 1'b1; f_eb = 16'hCD;
        #1;
        chk("flow_stall_dv", 32'(f_dv), 1);
        tick();
        f_ev = 1'b0;
        #1;
        chk("flow_stall_cnt", 32'(f_cnt), 1);
        chk("flow_stall_db", 32'(f_db), 16'hCD);
        f_dr = 1'b1;
        tick();
        f_dr = 1'b0; f_fl = 1'b1; f_ev = 1'b1; f_eb = 16'hEE; f_dr = 1'b1;
        #1;
        chk("flow_flush_dv", 32'(f_dv), 0);
        chk("flow_flush_er", 32'(f_er), 0);
        tick();
        f_fl = 1'b0; f_ev = 1'b0; f_dr = 1'b0;
        #1;
        chk("flow_flush_cnt", 32'(f_cnt), 0);

        // DROP_WHEN_FULL=1, DEPTH=2.
        for (int k = 1; k <= 5; k++) begin
            d_ev = 1'b1; d_eb = 16'(k); d_dr = 1'b0;
            #1;
            chk("drop_er", 32'(d_er), 1);
            tick();
        end
        d_ev = 1'b0;
        #1;
        chk("drop_cnt", 32'(d_cnt), 2);
        chk("drop_drops", 32'(d_drops), 3);
        chk("drop_head", 32'(d_db), 1);
        d_fl = 1'b1; d_ev = 1'b1;
        #1;
        chk("drop_flush_er", 32'(d_er), 0);
        chk("drop_flush_dv", 32'(d_dv), 0);
        tick();
        d_fl = 1'b0; d_ev = 1'b0;
        #1;
        chk("drop_flush_cnt", 32'(d_cnt), 0);
        chk("drop_flush_drops", 32'(d_drops), 3);
        chk("drop_flush_dvq", 32'(d_dv), 0);
        tick();
        d_ev = 1'b1; d_eb = 16'h8;
        tick();
        d_eb = 16'h9;
        tick();
        d_ev = 1'b0; d_dr = 1'b1;
        #1;
        chk("drop_order0", 32'(d_db), 16'h8);
        tick();
        #1;
        chk("drop_order1", 32'(d_db), 16'h9);
        tick();
        d_dr = 1'b0;
        notrdy = 0;
        d_ev = 1'b1;
        repeat (70000) begin
            if (d_er !== 1'b1) notrdy++;
            tick();
        end
        chk("drop_ready_const", 32'(notrdy), 0);
        d_ev = 1'b0;
        #1;
        chk("drop_saturated", 32'(d_drops), 16'hFFFF);
        chk("drop_sat_cnt", 32'(d_cnt), 2);
        tick();

        // Reset mid-stream with entries held and a producer still pushing.
        rst = 1'b1; d_ev = 1'b1;
        tick();
        #1;
        chk("midrst_d_er", 32'(d_er), 0);
        chk("midrst_d_dv", 32'(d_dv), 0);
        tick();
        rst = 1'b0; d_ev = 1'b0;
        #1;
        chk("after_rst_drops", 32'(d_drops), 0);
        chk("after_rst_er", 32'(d_er), 1);
        chk("after_rst_dv", 32'(d_dv), 0);
        chk("after_rst_cnt", 32'(d_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
